// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: a bank of JK flip-flops shared by two requesters.
// A round-robin arbiter grants one command at a time. The granted command
// executes in a single EXEC cycle. The winner then gets a one-cycle ack.
module jk_bank_arbiter #(
  parameter int N_BITS = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [1:0]        cmd0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [1:0]        cmd1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [N_BITS-1:0] Q,
  output logic [N_BITS-1:0] Q_bar,
  output logic              busy,
  output logic [7:0]        change_cnt
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  state_t            state, next_state;
  logic              win_q;       // 0: requester 0 owns the latched command
  logic              last_grant;  // requester granted most recently
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;

  logic elig0, elig1, grant_valid, grant_sel;
  logic cur_bit, new_bit;

  // Arbitration and next-state selection.
  // A requester whose ack is high this cycle is not eligible, so it cannot be re-granted.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
    next_state  = state;
    elig0       = req0 & ~ack0;
    elig1       = req1 & ~ack1;
    grant_valid = elig0 | elig1;
    grant_sel   = 1'b0;
    if (elig0 && elig1) grant_sel = ~last_grant;
    else                grant_sel = elig1;
    case (state)
      IDLE: if (grant_valid) next_state = EXEC;
      EXEC: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // JK rule applied to the addressed bit, using the latched command.
  always_comb begin
    cur_bit = Q[addr_q];
    new_bit = cur_bit;
    case (cmd_q)
      CMD_HOLD:   new_bit = cur_bit;
      CMD_RESET:  new_bit = 1'b0;
      CMD_SET:    new_bit = 1'b1;
      CMD_TOGGLE: new_bit = ~cur_bit;
      default:    new_bit = cur_bit;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Grant latch, bank update, ack pulse and change counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= 1'b0;
      last_grant <= 1'b1;
      cmd_q      <= CMD_HOLD;
      addr_q     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      Q          <= '0;
      change_cnt <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE && grant_valid) begin
        win_q      <= grant_sel;
        last_grant <= grant_sel;
        cmd_q      <= grant_sel ? cmd1  : cmd0;
        addr_q     <= grant_sel ? addr1 : addr0;
      end
      if (state == EXEC) begin
        Q[addr_q] <= new_bit;
        ack0      <= ~win_q;
        ack1      <= win_q;
        if (new_bit != cur_bit && change_cnt != 8'hFF)
          change_cnt <= change_cnt + 8'd1;
      end
    end
  end

  assign busy  = (state == EXEC);
  assign Q_bar = ~Q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed testbench for jk_bank_arbiter with hand-computed expectations.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] cmd0, cmd1;
  logic [1:0] addr0, addr1;
  logic       ack0, ack1, busy;
  logic [3:0] Q, Q_bar;
  logic [7:0] change_cnt;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(.N_BITS(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .addr1(addr1), .ack1(ack1),
    .Q(Q), .Q_bar(Q_bar), .busy(busy), .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester 0 command: returns in the ack cycle.
  task automatic run0(input logic [1:0] c, input logic [1:0] a);
    req0 = 1'b1; cmd0 = c; addr0 = a;
    tick();
    req0 = 1'b0;
    tick();
  endtask

  // Short reset pulse between edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cmd0 = 2'b00; cmd1 = 2'b00; addr0 = 2'd0; addr1 = 2'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_q",     32'(Q),          32'h0);
    check("rst_qbar",  32'(Q_bar),      32'hF);
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_acks",  32'({ack0, ack1}), 32'h0);
    check("rst_cnt",   32'(change_cnt), 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single set on bit 2, request dropped during EXEC.
    req0 = 1'b1; cmd0 = 2'b10; addr0 = 2'd2;
    tick();
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_ack_early", 32'(ack0), 32'h0);
    req0 = 1'b0;
    tick();
    check("t1_q",    32'(Q),          32'h4);
    check("t1_qbar", 32'(Q_bar),      32'hB);
    check("t1_ack0", 32'(ack0),       32'h1);
    check("t1_busy_low", 32'(busy),   32'h0);
    check("t1_cnt",  32'(change_cnt), 32'h1);
    tick();
    check("t1_ack_pulse", 32'(ack0), 32'h0);

    // Inputs changed during EXEC have no effect.
    req0 = 1'b1; cmd0 = 2'b11; addr0 = 2'd0;
    tick();
    check("t2_busy", 32'(busy), 32'h1);
    cmd0 = 2'b01; addr0 = 2'd3; req0 = 1'b0;
    tick();
    check("t2_q",   32'(Q),          32'h5);
    check("t2_ack", 32'(ack0),       32'h1);
    check("t2_cnt", 32'(change_cnt), 32'h2);
    tick();

    // JK truth table on bit 1.
    pulse_reset();
    check("t3_rst_q", 32'(Q), 32'h0);
    check("t3_rst_cnt", 32'(change_cnt), 32'h0);
    run0(2'b11, 2'd1); check("t3_toggle", 32'(Q), 32'h2); tick();
    run0(2'b00, 2'd1); check("t3_hold",   32'(Q), 32'h2); tick();
    run0(2'b01, 2'd1); check("t3_reset",  32'(Q), 32'h0); tick();
    run0(2'b10, 2'd1); check("t3_set",    32'(Q), 32'h2); tick();
    run0(2'b10, 2'd1); check("t3_set2",   32'(Q), 32'h2);
    check("t3_cnt", 32'(change_cnt), 32'h3);
    tick();

    // Tie and rotation: toggle bit 0 from req0, bit 1 from req1.
    pulse_reset();
    cmd0 = 2'b11; addr0 = 2'd0; cmd1 = 2'b11; addr1 = 2'd1;
    req0 = 1'b1; req1 = 1'b1;
    tick(); check("rr1_busy", 32'(busy), 32'h1); check("rr1_acks", 32'({ack0, ack1}), 32'h0);
    tick(); check("rr2_acks", 32'({ack0, ack1}), 32'h2); check("rr2_q", 32'(Q), 32'h1);
    tick(); check("rr3_busy", 32'(busy), 32'h1); check("rr3_acks", 32'({ack0, ack1}), 32'h0);
    tick(); check("rr4_acks", 32'({ack0, ack1}), 32'h1); check("rr4_q", 32'(Q), 32'h3);
    tick(); check("rr5_busy", 32'(busy), 32'h1); check("rr5_acks", 32'({ack0, ack1}), 32'h0);
    tick(); check("rr6_acks", 32'({ack0, ack1}), 32'h2); check("rr6_q", 32'(Q), 32'h2);
    tick(); check("rr7_busy", 32'(busy), 32'h1); check("rr7_acks", 32'({ack0, ack1}), 32'h0);
    tick(); check("rr8_acks", 32'({ack0, ack1}), 32'h1); check("rr8_q", 32'(Q), 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    check("rr_cnt", 32'(change_cnt), 32'h4);
    tick(); check("rr_idle", 32'(busy), 32'h0);

    // Lone requester 1 wins even though it was granted last.
    req1 = 1'b1; cmd1 = 2'b10; addr1 = 2'd2;
    tick(); check("r1_busy", 32'(busy), 32'h1);
    req1 = 1'b0;
    tick();
    check("r1_acks", 32'({ack0, ack1}), 32'h1);
    check("r1_q", 32'(Q), 32'h4);
    tick();

    // Saturation: 300 toggles on bit 0.
    pulse_reset();
    for (int i = 0; i < 255; i++) begin
      run0(2'b11, 2'd0);
      tick();
    end
    check("sat_cnt_255", 32'(change_cnt), 32'hFF);
    check("sat_q_odd",   32'(Q),          32'h1);
    for (int i = 0; i < 45; i++) begin
      run0(2'b11, 2'd0);
      tick();
    end
    check("sat_cnt_hold", 32'(change_cnt), 32'hFF);
    check("sat_q_end",    32'(Q),          32'h0);

    // Reset during EXEC discards the command; held request is re-arbitrated.
    pulse_reset();
    req0 = 1'b1; cmd0 = 2'b10; addr0 = 2'd3;
    tick();
    check("mr_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("mr_q",    32'(Q),     32'h0);
    check("mr_qbar", 32'(Q_bar), 32'hF);
    check("mr_busy_rst", 32'(busy), 32'h0);
    tick();
    check("mr_no_ack", 32'({ack0, ack1}), 32'h0);
    check("mr_q_held", 32'(Q), 32'h0);
    rst = 1'b0;
    tick();
    check("mr_regrant", 32'(busy), 32'h1);
    tick();
    check("mr_q_after", 32'(Q),    32'h8);
    check("mr_ack0",    32'(ack0), 32'h1);
    req0 = 1'b0;
    tick();
    check("mr_ack_end", 32'(ack0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter N_BITS, default 4: number of JK flip-flops in the bank.
REQ-002 Parameter ADDR_W, default 2: address width; N_BITS SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  requester 0 command request; level, held until ack0.
REQ-006 cmd0  input  2  requester 0 command: 00 hold (J0K0), 01 reset (J0K1), 10 set (J1K0), 11 toggle (J1K1).
REQ-007 addr0  input  ADDR_W  requester 0 target bit index.
REQ-008 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-009 req1 / cmd1 / addr1 / ack1: same widths and meaning as REQ-005..REQ-008, for requester 1.
REQ-010 Q  output  N_BITS  bank state.
REQ-011 Q_bar  output  N_BITS  bitwise complement of Q at all times, including during reset.
REQ-012 busy  output  1  high while a granted command is executing (state EXEC).
REQ-013 change_cnt  output  8  saturating count of executed commands that changed a Q bit.

Function
REQ-014 The FSM SHALL have two states: IDLE and EXEC.
REQ-015 IDLE: an eligible request SHALL latch the winner, cmd and addr, then go to EXEC on the next edge. Otherwise the FSM SHALL stay in IDLE.
REQ-016 Eligible: reqN high and ackN low in that cycle. A requester acked this cycle SHALL NOT be re-granted in the same cycle.
REQ-017 Arbitration SHALL be round-robin. With one eligible requester, that requester wins. With both eligible, the requester not granted last wins.
REQ-018 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 EXEC, at the next edge: Q[addr] SHALL update per JK rule on latched cmd (hold keeps, reset ->0, set ->1, toggle ->~Q). The winner's ack SHALL pulse high for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency: from req sampled high in IDLE to the Q update and ack-high cycle SHALL be 2 clock edges. Peak throughput SHALL be one command per 2 cycles.
REQ-021 Only the addressed bit SHALL change. All other Q bits SHALL hold.
REQ-022 cmd/addr SHALL be captured at grant. Input changes during EXEC SHALL have no effect.
REQ-023 A request dropped during EXEC SHALL still complete and ack.
REQ-024 change_cnt SHALL increment by 1 on an EXEC completion where Q[addr] changes value. It SHALL saturate at 255, with no wrap.
REQ-025 Hold, set-on-1 and reset-on-0 SHALL NOT increment change_cnt.
REQ-026 ack0 and ack1 SHALL never be high in the same cycle.
REQ-027 busy SHALL be high exactly in EXEC cycles.

Reset
REQ-028 On rst high, immediately and independent of clk: Q=0, Q_bar=all 1s, ack0=ack1=0, busy=0, change_cnt=0, state=IDLE, last grant=1.
REQ-029 A reset during EXEC SHALL discard the command with no ack. A requester still holding req SHALL be re-arbitrated after reset release.
REQ-030 On the first rising edge after rst falls, a request SHALL be arbitrated normally with no extra delay.

Verification
REQ-031 Single command: req0, cmd0=10, addr0=2 -> busy next cycle; then Q=0100, Q_bar=1011, ack0 pulses 1 cycle, change_cnt=1.
REQ-032 Tie and rotation: req0 and req1 both high, held after ack -> grants 0,1,0,1. ack0 and ack1 alternate every 2 cycles and never overlap.
REQ-033 JK truth table on bit 1 from Q=0000:
- toggle -> 0010
- hold -> 0010
- reset -> 0000
- set -> 0010
- set -> 0010
- Final: change_cnt=3; other bits constant.
REQ-034 Saturation: 300 toggles on bit 0 -> change_cnt reaches 255 and stays 255. Q[0] ends at 0.
REQ-035 Mid-operation reset: rst asserted during EXEC of a set on bit 3 -> Q=0000, Q_bar=1111, no ack. After release with req0 held -> Q=1000 two edges later, ack0 pulses.
REQ-036 Input changes during EXEC: cmd0/addr0 changed in EXEC cycle -> the originally latched command and address are applied.
